// File: rtl/syn_fifo_ctl.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds and sticky error flags.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read port.
module syn_fifo_ctl #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             re,
    input  logic [WIDTH-1:0] din,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [AW:0]      count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_AF   = (AW + 1)'(AF_LEVEL);
    localparam logic [AW:0] CNT_AE   = (AW + 1)'(AE_LEVEL);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] dout_q;
    logic             rd_ok;
    logic             wr_ok;
    logic [AW:0]      count_nxt;

    // Request semantics: we/re are single-cycle requests sampled every edge, no stall.
    // A request that cannot be honoured is dropped and raises the sticky error flag;
    // a write into a full FIFO is honoured only when a read frees a slot on the same edge.
    always_comb begin
        rd_ok     = re && !empty;
        wr_ok     = we && (!full || rd_ok);
        count_nxt = count;
        if (wr_ok && !rd_ok) begin
            count_nxt = count + CNT_ONE;
        end else if (rd_ok && !wr_ok) begin
            count_nxt = count - CNT_ONE;
        end
    end

    // Storage is deliberately not reset; reset only discards it through the pointers.
    always_ff @(posedge clk) begin
        if (rst && wr_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == CNT_FULL);
            almost_full  <= (count_nxt >= CNT_AF);
            almost_empty <= (count_nxt <= CNT_AE);
            // A new error in the same cycle as err_clr must not be lost.
            if (we && !wr_ok) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (re && empty) begin
                underflow <= 1'b1;
            end else if (err_clr) begin
                underflow <= 1'b0;
            end
        end
    end

    // dout_q holds the most recently popped word in both read modes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q <= '0;
        end else if (rd_ok) begin
            dout_q <= mem[rd_ptr];
        end
    end

`ifdef SYN_FIFO_FWFT_EN
    assign dout = empty ? dout_q : mem[rd_ptr];
`else
    assign dout = dout_q;
`endif

endmodule

// File: tb/tb_syn_fifo_ctl.sv
// Directed bench for syn_fifo_ctl at default parameters; expected words tracked in exp_q.
module tb_syn_fifo_ctl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         we = 1'b0;
    logic         re = 1'b0;
    logic [W-1:0] din = '0;
    logic         err_clr = 1'b0;
    logic [W-1:0] dout;
    logic         full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]   count;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] last_pop = '0;

    syn_fifo_ctl dut (
        .clk(clk), .rst(rst), .we(we), .re(re), .din(din), .err_clr(err_clr),
        .dout(dout), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow),
        .underflow(underflow)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic push(input logic [W-1:0] d);
        we = 1'b1; din = d;
        tick();
        we = 1'b0;
        exp_q.push_back(d);
    endtask

    // Pops one word and compares it with the scoreboard head; in FWFT mode the
    // head is visible before the edge, otherwise one edge after re is sampled.
    task automatic pop_check(input string tag);
        logic [W-1:0] e;
        e = exp_q.pop_front();
        re = 1'b1;
`ifdef SYN_FIFO_FWFT_EN
        check(tag, dout, e);
`endif
        tick();
        re = 1'b0;
`ifndef SYN_FIFO_FWFT_EN
        check(tag, dout, e);
`endif
        last_pop = e;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_ae"}, almost_empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_af"}, almost_full, 0);
        check({tag, "_ovf"}, overflow, 0);
        check({tag, "_unf"}, underflow, 0);
        check({tag, "_dout"}, dout, 0);
    endtask

    initial begin
        // reset
        rst = 1'b0;
        tick(); tick();
        rst = 1'b1;
        check_reset_state("rst0");

        // 1: fill 0x00..0x0F, watch thresholds, then overflow
        for (int i = 0; i < 16; i++) begin
            push(W'(i));
            check("fill_count", count, i + 1);
            check("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
            check("fill_af", almost_full, (i + 1 >= 14) ? 1 : 0);
            check("fill_full", full, (i + 1 == 16) ? 1 : 0);
        end
        we = 1'b1; din = 8'h10;
        tick();
        we = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 16);
        check("ovf_full", full, 1);

        // 2: drain 16, then one underflowing read
        for (int i = 0; i < 16; i++) begin
            pop_check("drain1");
            check("drain1_count", count, 15 - i);
        end
        check("drain1_empty", empty, 1);
        re = 1'b1;
        tick();
        re = 1'b0;
        check("unf_set", underflow, 1);
        check("unf_dout_hold", dout, 8'h0F);
        check("unf_ovf_sticky", overflow, 1);
        // error raised and cleared on the same edge: set must win
        re = 1'b1; err_clr = 1'b1;
        tick();
        re = 1'b0;
        check("clr_vs_set_unf", underflow, 1);
        check("clr_vs_set_ovf", overflow, 0);
        tick();
        err_clr = 1'b0;
        check("clr_unf", underflow, 0);
        check("clr_ovf", overflow, 0);

        // 3: simultaneous read/write while full
        for (int i = 0; i < 16; i++) push(W'(i));
        check("refill_full", full, 1);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            exp_q.push_back(W'(8'hA0 + i));
            we = 1'b1; re = 1'b1; din = W'(8'hA0 + i);
`ifdef SYN_FIFO_FWFT_EN
            check("rw_full_dout", dout, e);
`endif
            tick();
`ifndef SYN_FIFO_FWFT_EN
            check("rw_full_dout", dout, e);
`endif
            check("rw_full_count", count, 16);
            check("rw_full_full", full, 1);
            check("rw_full_ovf", overflow, 0);
        end
        we = 1'b0; re = 1'b0;
        while (exp_q.size() > 0) pop_check("drain3");
        check("drain3_empty", empty, 1);

        // 4: simultaneous read/write while empty
        we = 1'b1; re = 1'b1; din = 8'h55;
        tick();
        we = 1'b0; re = 1'b0;
        exp_q.push_back(8'h55);
        check("rw_empty_count", count, 1);
        check("rw_empty_empty", empty, 0);
        check("rw_empty_unf", underflow, 1);
        pop_check("rw_empty_read");
        check("rw_empty_after", count, 0);

        // 5: pointer wrap
        for (int i = 0; i < 10; i++) push(W'(8'h30 + i));
        for (int i = 0; i < 10; i++) pop_check("wrap_pre");
        for (int i = 0; i < 12; i++) push(W'(8'h20 + i));
        check("wrap_count12", count, 12);
        for (int i = 0; i < 12; i++) pop_check("wrap_order");
        check("wrap_count0", count, 0);
        check("wrap_empty", empty, 1);

        // 6: mid-operation reset (underflow is still set from step 4)
        for (int i = 0; i < 5; i++) push(W'(8'h60 + i));
        check("pre_rst_count", count, 5);
        check("pre_rst_unf", underflow, 1);
        we = 1'b1; re = 1'b1; err_clr = 1'b1; din = 8'hEE; rst = 1'b0;
        tick();
        we = 1'b0; re = 1'b0; err_clr = 1'b0; rst = 1'b1;
        exp_q.delete();
        check_reset_state("rst1");
        re = 1'b1;
        tick();
        re = 1'b0;
        check("post_rst_unf", underflow, 1);
        check("post_rst_count", count, 0);

`ifdef SYN_FIFO_FWFT_EN
        we = 1'b1; din = 8'h77;
        tick();
        we = 1'b0;
        check("fwft_dout", dout, 8'h77);
        check("fwft_empty", empty, 0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
